// File: rtl/string_hw_pkg.sv
// string_hw_pkg: register map, control/status bit positions and FSM states for the string accelerator bridge
package string_hw_pkg;
  localparam logic [2:0] ADDR_CH0  = 3'd0;
  localparam logic [2:0] ADDR_RES  = 3'd4;
  localparam logic [2:0] ADDR_CTRL = 3'd5;
  localparam logic [2:0] ADDR_CNT  = 3'd6;
  localparam int CTRL_GO    = 0;
  localparam int CTRL_FLUSH = 1;
  localparam int CTRL_CLR   = 2;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_REMPTY  = 2;
  localparam int ST_RFULL   = 3;
  localparam int ST_CHFULL  = 4;
  localparam int ST_CHEMPTY = 8;
  localparam int ST_OVF     = 12;
  localparam int ST_UNF     = 13;
  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY} state_t;
endpackage

// File: rtl/string_sync_fifo.sv
// string_sync_fifo: single-clock FIFO with flush, full-with-pop push acceptance and overflow/underflow strobes
module string_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_push,
  input  logic [DATA_W-1:0]         i_din,
  input  logic                      i_pop,
  input  logic                      i_flush,
  output logic [DATA_W-1:0]         o_head,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_ovf,
  output logic                      o_unf
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign o_empty = r_cnt == '0;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign w_push  = i_push & ~i_flush & (~o_full | w_pop);
  assign o_ovf   = i_push & ~i_flush & o_full & ~w_pop;
  assign o_unf   = i_pop & ~i_flush & o_empty;
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/string_fifo_avalon_mc.sv
// string_fifo_avalon_mc: Avalon-MM slave with NUM_CH input FIFOs, a result FIFO and go/busy/done control
module string_fifo_avalon_mc
  import string_hw_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 16,
  parameter int          NUM_CH    = 2,
  parameter logic [31:0] EMPTY_VAL = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     chipselect,
  input  logic [2:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  input  logic                     read,
  output logic [31:0]              readdata,
  output logic                     go,
  input  logic                     done,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_ready,
  input  logic [DATA_W-1:0]        res_data,
  input  logic                     res_valid,
  output logic                     res_ready
);
  localparam int AW = $clog2(DEPTH);
  logic w_wr, w_rd, w_ctrl, w_go_req, w_flush, w_clr, w_busy;
  logic [NUM_CH-1:0] w_ch_full, w_ch_empty, w_ch_ovf, w_ch_unf;
  logic [NUM_CH-1:0][AW:0] w_ch_cnt;
  logic [DATA_W-1:0] w_res_head;
  logic [AW:0] w_res_cnt;
  logic w_res_full, w_res_empty, w_res_ovf, w_res_unf;
  logic [31:0] w_status, w_counts, w_rdata;
  logic [31:0] r_readdata;
  logic r_done, r_ovf, r_unf;
  state_t r_state, w_next;
  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read;
  assign w_ctrl   = w_wr && address == ADDR_CTRL;
  assign w_go_req = w_ctrl & writedata[CTRL_GO];
  assign w_flush  = w_ctrl & writedata[CTRL_FLUSH];
  assign w_clr    = w_ctrl & writedata[CTRL_CLR];
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    string_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_wr && address == ADDR_CH0 + 3'(c)),
      .i_din   (writedata),
      .i_pop   (ch_ready[c] & ch_valid[c]),
      .i_flush (w_flush),
      .o_head  (ch_data[c*DATA_W +: DATA_W]),
      .o_count (w_ch_cnt[c]),
      .o_full  (w_ch_full[c]),
      .o_empty (w_ch_empty[c]),
      .o_ovf   (w_ch_ovf[c]),
      .o_unf   (w_ch_unf[c])
    );
  end
  assign ch_valid = ~w_ch_empty;
  // Core only transfers when ready, so a full result FIFO never counts as overflow
  string_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_res (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (res_valid & res_ready),
    .i_din   (res_data),
    .i_pop   (w_rd && address == ADDR_RES),
    .i_flush (w_flush),
    .o_head  (w_res_head),
    .o_count (w_res_cnt),
    .o_full  (w_res_full),
    .o_empty (w_res_empty),
    .o_ovf   (w_res_ovf),
    .o_unf   (w_res_unf)
  );
  assign res_ready = ~w_res_full;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_IDLE ? (w_go_req ? S_START : S_IDLE) : (done ? S_IDLE : S_BUSY);
  end
  assign go     = r_state == S_START;
  assign w_busy = r_state != S_IDLE;
  always_comb begin
    w_status = '0;
    w_counts = '0;
    w_status[ST_BUSY]   = w_busy;
    w_status[ST_DONE]   = r_done;
    w_status[ST_REMPTY] = w_res_empty;
    w_status[ST_RFULL]  = w_res_full;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_UNF]    = r_unf;
    w_counts[7:0]       = 8'(w_res_cnt);
    for (int c = 0; c < NUM_CH; c++) begin
      w_status[ST_CHFULL+c]  = w_ch_full[c];
      w_status[ST_CHEMPTY+c] = w_ch_empty[c];
      w_counts[8+8*c +: 8]   = 8'(w_ch_cnt[c]);
    end
    w_rdata = address == ADDR_RES  ? (w_res_empty ? EMPTY_VAL : w_res_head) :
              address == ADDR_CTRL ? w_status :
              address == ADDR_CNT  ? w_counts : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_done <= (r_done & ~w_clr) | (done & w_busy);
      r_ovf  <= (r_ovf & ~w_clr) | (|{w_ch_ovf, w_res_ovf});
      r_unf  <= (r_unf & ~w_clr) | (|{w_ch_unf, w_res_unf});
      if (w_rd) r_readdata <= w_rdata;
    end
  assign readdata = r_readdata;
endmodule

// File: tb/tb_string_fifo_avalon_mc.sv
// tb_string_fifo_avalon_mc: directed bench for the Avalon FIFO bridge with hand-computed expectations
module tb_string_fifo_avalon_mc;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic go, done = 1'b0;
  logic [63:0] ch_data;
  logic [1:0] ch_valid, ch_ready = '0;
  logic [31:0] res_data = '0;
  logic res_valid = 1'b0, res_ready;
  int n_chk = 0, n_fail = 0;

  string_fifo_avalon_mc dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .go(go), .done(done), .ch_data(ch_data), .ch_valid(ch_valid), .ch_ready(ch_ready),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick;
    chipselect = 1'b0; read = 1'b0;
    chk(tag, readdata, exp);
  endtask

  task automatic pulse_done;
    done = 1'b1;
    tick;
    done = 1'b0;
  endtask

  initial begin
    tick;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_go", 32'(go), 32'h0);
    chk("rst_ch_valid", 32'(ch_valid), 32'h0);
    chk("rst_res_ready", 32'(res_ready), 32'h1);
    #2 reset_n = 1'b1;
    tick;
    rdchk("rst_status", 3'd5, 32'h0000_0304);
    // ch0 fill to full, overflow, drain
    for (int i = 0; i < 16; i++) wr(3'd0, 32'h11 + i);
    rdchk("full_status", 3'd5, 32'h0000_0214);
    rdchk("full_counts", 3'd6, 32'h0000_1000);
    wr(3'd0, 32'h99);
    rdchk("ovf_status", 3'd5, 32'h0000_1214);
    rdchk("chan_read_zero", 3'd0, 32'h0);
    ch_ready = 2'b01;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", ch_data[31:0], 32'h11 + i);
      tick;
    end
    chk("drain_valid", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00;
    wr(3'd5, 32'h4);
    rdchk("clr_status", 3'd5, 32'h0000_0304);
    // result FIFO
    res_valid = 1'b1; res_data = 32'hA5A5A5A5;
    tick;
    res_data = 32'h5A5A5A5A;
    tick;
    res_valid = 1'b0;
    rdchk("res_counts", 3'd6, 32'h0000_0002);
    rdchk("res_pop0", 3'd4, 32'hA5A5A5A5);
    rdchk("res_pop1", 3'd4, 32'h5A5A5A5A);
    rdchk("res_empty", 3'd4, 32'hDEADBEEF);
    tick;
    chk("readdata_hold", readdata, 32'hDEADBEEF);
    rdchk("unf_status", 3'd5, 32'h0000_2304);
    rdchk("unmapped", 3'd7, 32'h0);
    // GO/done handshake
    wr(3'd5, 32'h4);
    wr(3'd5, 32'h1);
    chk("go_pulse", 32'(go), 32'h1);
    rdchk("busy_status", 3'd5, 32'h0000_0305);
    chk("go_one_cycle", 32'(go), 32'h0);
    wr(3'd5, 32'h1);
    chk("go_ignored", 32'(go), 32'h0);
    pulse_done;
    rdchk("done_status", 3'd5, 32'h0000_0306);
    wr(3'd5, 32'h4);
    rdchk("done_clr", 3'd5, 32'h0000_0304);
    pulse_done;
    rdchk("idle_done", 3'd5, 32'h0000_0304);
    // ch1 full with simultaneous push and pop across the pointer wrap
    for (int i = 0; i < 16; i++) wr(3'd1, 32'h100 + i);
    for (int k = 0; k < 4; k++) begin
      chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h110 + k;
      ch_ready = 2'b10;
      chk("wrap_head", ch_data[63:32], 32'h100 + k);
      tick;
    end
    chipselect = 1'b0; write = 1'b0; ch_ready = 2'b00;
    rdchk("wrap_counts", 3'd6, 32'h0010_0000);
    rdchk("wrap_status", 3'd5, 32'h0000_0124);
    ch_ready = 2'b10;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_drain", ch_data[63:32], 32'h104 + i);
      tick;
    end
    ch_ready = 2'b00;
    // FLUSH while busy
    wr(3'd5, 32'h1);
    for (int i = 0; i < 5; i++) wr(3'd0, 32'h200 + i);
    rdchk("pre_flush_counts", 3'd6, 32'h0000_0500);
    wr(3'd5, 32'h2);
    rdchk("flush_counts", 3'd6, 32'h0);
    rdchk("flush_status", 3'd5, 32'h0000_0305);
    chk("flush_valid", 32'(ch_valid), 32'h0);
    pulse_done;
    wr(3'd5, 32'h4);
    // asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) wr(3'd0, 32'h300 + i);
    rdchk("pre_rst_counts", 3'd6, 32'h0000_0300);
    wr(3'd5, 32'h1);
    chk("pre_rst_go", 32'(go), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_readdata", readdata, 32'h0);
    chk("arst_go", 32'(go), 32'h0);
    chk("arst_valid", 32'(ch_valid), 32'h0);
    chk("arst_res_ready", 32'(res_ready), 32'h1);
    #2 reset_n = 1'b1;
    tick;
    rdchk("post_rst_counts", 3'd6, 32'h0);
    rdchk("post_rst_status", 3'd5, 32'h0000_0304);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/string_fifo_avalon_mc.md
Name: string_fifo_avalon_mc

Overview:
Parametrised Avalon-MM slave sitting between the Nios II and the string HW accelerator core. It provides NUM_CH CPU-write input FIFOs, each drained by the core over a valid/ready stream, and one result FIFO filled by the core and popped by CPU reads. It also provides a go/busy/done control handshake and full/empty/count status. All index updates are on clk; there is no read/write-strobe clocking.

Parameters:
DATA_W, 32, FIFO word and Avalon data width (fixed 32 for this bus)
DEPTH, 16, entries per FIFO, power of 2, 2..128
NUM_CH, 2, input channels, 1..3
EMPTY_VAL, 32'hDEADBEEF, readdata on result-FIFO read while empty

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
chipselect  in  1  Avalon select
address  in  3  Avalon word address
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
read  in  1  Avalon read strobe
readdata  out  32  Avalon read data, registered, readLatency 1
go  out  1  one-cycle start pulse to core
done  in  1  one-cycle completion pulse from core
ch_data  out  NUM_CH*DATA_W  input FIFO heads, ch0 in LSBs
ch_valid  out  NUM_CH  input FIFO not empty
ch_ready  in  NUM_CH  core pops channel this cycle when valid&ready
res_data  in  DATA_W  result word from core
res_valid  in  1  core offers result
res_ready  out  1  = result FIFO not full

Behaviour:
- Reset (reset_n=0, async): readdata=0, go=0, busy=0, done flag=0, sticky flags=0, all FIFO pointers/counts=0 (ch_valid=0, res_ready=1). FIFO storage is not reset.
- Address map; any access with chipselect=0 is ignored:
  - 0..NUM_CH-1: write pushes channel; read returns 0, no pop.
  - 4: read pops result FIFO; write ignored.
  - 5: write is CTRL; read is STATUS.
  - 6: read is COUNTS; write ignored.
  - Unmapped address: reads return 0, writes ignored.
- Read latency: readdata is valid on the cycle after read&chipselect. It holds its value until the next read.
- One push or pop per cycle in which the strobe is high; the bus asserts each strobe for exactly 1 cycle (no waitrequest).
- FIFO rules (all FIFOs):
  - Push and pop in the same cycle are both honoured when not empty; count is unchanged.
  - Full with concurrent pop: push is accepted.
  - Full without pop: push is dropped and sets sticky OVF.
  - Empty: pop is impossible, and there is no bypass from push to pop.
  - Pointers wrap mod DEPTH; count is 0..DEPTH.
- Result read while empty: readdata=EMPTY_VAL, sets sticky UNF, pointers unchanged.
- CTRL write bits: [0] GO, [1] FLUSH (all FIFOs to empty), [2] CLRSTICKY (clears OVF, UNF, DONE).
- GO handshake:
  - GO while busy=0: go pulses high the next cycle and busy is set.
  - GO while busy=1: ignored.
  - done while busy: busy cleared, DONE sticky set.
  - done while idle: ignored.
  - go and done coincident: done wins the busy update (busy=0).
- FLUSH mid-operation empties the FIFOs but does not touch busy. FLUSH with a simultaneous push or pop: flush wins.
- FLUSH and CLRSTICKY in the same write are both performed; GO with FLUSH also starts the core.
- STATUS read bits:
  - [0] busy, [1] DONE, [2] result empty, [3] result full
  - [4+c] ch c full, [8+c] ch c empty
  - [12] OVF, [13] UNF
  - others 0
- COUNTS read: [7:0] result count; [15+8c:8+8c] ch c count; upper bits 0.
- FSM per instance: IDLE -> (GO) START (1 cycle, go=1) -> BUSY -> (done) IDLE. Async reset returns to IDLE from any state.

Decomposition:
- Package string_hw_pkg holds:
  - address constants ADDR_CH0, ADDR_RES=4, ADDR_CTRL=5, ADDR_CNT=6
  - CTRL and STATUS bit-index localparams
  - FSM state enum
- Sub-module string_sync_fifo (DATA_W, DEPTH):
  - inputs push, pop, flush
  - outputs head, count, full, empty, ovf/unf strobes
  - instantiated NUM_CH+1 times

Test Plan:
1. Push 16 words 0x11..0x20 to ch0 (DEPTH=16) -> STATUS[4]=1, COUNTS[15:8]=16. A 17th push sets STATUS[12]. Drain with ch_ready=1 -> ch_data sequence 0x11..0x20, ch_valid drops after 16.
2. Core pushes 0xA5A5A5A5, 0x5A5A5A5A on res -> reads of addr 4 return them in order, 1 cycle after read. A third read returns 0xDEADBEEF and sets STATUS[13].
3. Write CTRL=1 -> go pulses 1 cycle and STATUS[0]=1. A second GO produces no pulse. done pulse -> STATUS[1:0]=2'b10. CTRL=4 -> STATUS[1]=0.
4. Full ch1 with simultaneous CPU push and ch_ready pop -> count stays 16, no OVF, order preserved across pointer wrap.
5. FLUSH during BUSY with 5 words in ch0 -> all counts 0, busy still 1, ch_valid=0.
6. Assert reset_n=0 mid-burst, asynchronous to clk -> readdata=0, go=0, counts 0, res_ready=1 immediately, without waiting for a clock edge.
